// File: rtl/control_unit_pkg.sv
// Shared CPU definitions: state encodings, opcodes and instruction field layout.
package cpu_pkg;

    localparam int unsigned INSTR_W = 9;

    // Instruction word layout: {op, rx, ry}
    localparam int unsigned OP_MSB = 8;
    localparam int unsigned OP_LSB = 6;
    localparam int unsigned RX_MSB = 5;
    localparam int unsigned RX_LSB = 3;
    localparam int unsigned RY_MSB = 2;
    localparam int unsigned RY_LSB = 0;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_MOVE = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_TERM = 3'b100;

    typedef enum logic [3:0] {
        ST_START = 4'b0000,
        ST_LOAD  = 4'b0001,
        ST_MOVE  = 4'b0010,
        ST_ALU   = 4'b0011,
        ST_ALU2  = 4'b0100,
        ST_ALU3  = 4'b0101,
        ST_TERM  = 4'b0110,
        ST_DONE  = 4'b1111
    } state_t;

    function automatic logic [2:0] get_op(input logic [INSTR_W-1:0] w);
        return w[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [2:0] get_rx(input logic [INSTR_W-1:0] w);
        return w[RX_MSB:RX_LSB];
    endfunction

    function automatic logic [2:0] get_ry(input logic [INSTR_W-1:0] w);
        return w[RY_MSB:RY_LSB];
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Instruction-source handshake bundle: word, valid and ready.
interface control_unit_if;
    import cpu_pkg::*;

    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;

    modport master (output instr, output instr_valid, input instr_ready);
    modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/control_unit_dec3to8.sv
// 3-bit index to one-hot decoder with enable; all zeros when disabled.
module dec3to8 #(
    parameter int unsigned NREG = 8
) (
    input  logic [2:0]      sel,
    input  logic            en,
    output logic [NREG-1:0] onehot
);

    // Set the single bit addressed by sel when enabled.
    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (en && (32'(sel) == i)) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/control_unit.sv
// Instruction issue and datapath strobe sequencer for the basic CPU.
module control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned NREG  = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    control_unit_if.slave    bus,
    output logic [3:0]       state,
    output logic [NREG-1:0]  rin,
    output logic [NREG-1:0]  rout,
    output logic             din_out,
    output logic             a_in,
    output logic             g_in,
    output logic             g_out,
    output logic             alu_op,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    state_t             state_q;
    state_t             state_d;
    logic [INSTR_W-1:0] ir_q;
    logic [CNT_W-1:0]   ret_q;
    logic               ready;
    logic               hs;
    logic               rin_en;
    logic [2:0]         rin_sel;
    logic               rout_en;
    logic [2:0]         rout_sel;

    assign hs = bus.instr_valid & ready;

    // State register, instruction register and retired counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_START;
            ir_q    <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            if (hs && (state_q == ST_START)) begin
                ir_q <= bus.instr;
            end
            if (state_q == ST_DONE) begin
                ret_q <= ret_q + 1'b1;
            end
        end
    end

    // Next-state and strobe decode from the current state, IR and valid.
    always_comb begin
        state_d  = ST_START;
        ready    = 1'b0;
        rin_en   = 1'b0;
        rin_sel  = get_rx(ir_q);
        rout_en  = 1'b0;
        rout_sel = get_ry(ir_q);
        din_out  = 1'b0;
        a_in     = 1'b0;
        g_in     = 1'b0;
        g_out    = 1'b0;
        alu_op   = 1'b0;
        case (state_q)
            ST_START: begin
                ready = 1'b1;
                if (hs) begin
                    case (get_op(bus.instr))
                        OP_LOAD:        state_d = ST_LOAD;
                        OP_MOVE:        state_d = ST_MOVE;
                        OP_ADD, OP_XOR: state_d = ST_ALU;
                        OP_TERM:        state_d = ST_TERM;
                        default:        state_d = ST_DONE;
                    endcase
                end else begin
                    state_d = ST_START;
                end
            end
            ST_LOAD: begin
                ready = 1'b1;
                if (hs) begin
                    din_out = 1'b1;
                    rin_en  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_MOVE: begin
                rout_en = 1'b1;
                rin_en  = 1'b1;
                state_d = ST_DONE;
            end
            ST_ALU: begin
                rout_en  = 1'b1;
                rout_sel = get_rx(ir_q);
                a_in     = 1'b1;
                state_d  = ST_ALU2;
            end
            ST_ALU2: begin
                rout_en = 1'b1;
                g_in    = 1'b1;
                alu_op  = ir_q[OP_LSB];
                state_d = ST_ALU3;
            end
            ST_ALU3: begin
                g_out   = 1'b1;
                rin_en  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_START;
            ST_TERM: state_d = ST_TERM;
            default: state_d = ST_START;
        endcase
    end

    dec3to8 #(.NREG(NREG)) u_rin_dec (
        .sel    (rin_sel),
        .en     (rin_en),
        .onehot (rin)
    );

    dec3to8 #(.NREG(NREG)) u_rout_dec (
        .sel    (rout_sel),
        .en     (rout_en),
        .onehot (rout)
    );

    assign bus.instr_ready = ready & ~reset;
    assign state           = state_q;
    assign halted          = (state_q == ST_TERM);
    assign retired         = ret_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed cases plus a randomized instruction stream.
module tb_control_unit;
    import cpu_pkg::*;

    localparam int unsigned NREG = 8;
    localparam int unsigned CW   = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      state;
    logic [NREG-1:0] rin;
    logic [NREG-1:0] rout;
    logic            din_out;
    logic            a_in;
    logic            g_in;
    logic            g_out;
    logic            alu_op;
    logic            halted;
    logic [CW-1:0]   retired;

    control_unit_if cu_bus ();

    control_unit #(.NREG(NREG), .CNT_W(CW)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (cu_bus),
        .state   (state),
        .rin     (rin),
        .rout    (rout),
        .din_out (din_out),
        .a_in    (a_in),
        .g_in    (g_in),
        .g_out   (g_out),
        .alu_op  (alu_op),
        .halted  (halted),
        .retired (retired)
    );

    always #5 clk = ~clk;

    // Expected per-cycle observation; drv selects how the bench drives the bus that cycle:
    // 0 = valid low, 1 = valid high with immediate, 2 = random valid/word, 3 = valid high random word
    typedef struct {
        logic [3:0]      st;
        logic [NREG-1:0] rin;
        logic [NREG-1:0] rout;
        logic            din;
        logic            ain;
        logic            gin;
        logic            gout;
        logic            aop;
        logic            rdy;
        logic            hlt;
        int              drv;
    } exp_t;

    exp_t        expq[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int unsigned ret_model = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t quiet(input logic [3:0] st);
        exp_t e;
        e.st = st; e.rin = '0; e.rout = '0; e.din = 1'b0; e.ain = 1'b0;
        e.gin = 1'b0; e.gout = 1'b0; e.aop = 1'b0; e.rdy = 1'b0; e.hlt = 1'b0;
        e.drv = 2;
        return e;
    endfunction

    function automatic logic [NREG-1:0] bit_of(input logic [2:0] r);
        return NREG'(1) << r;
    endfunction

    // Expected cycle list after the START cycle, derived from what each opcode must do on the datapath.
    task automatic build(input logic [8:0] w, input int delay);
        logic [2:0] op;
        logic [2:0] rx;
        logic [2:0] ry;
        exp_t       e;
        op = w[8:6]; rx = w[5:3]; ry = w[2:0];
        expq.delete();
        case (op)
            3'd0: begin
                for (int i = 0; i < delay; i++) begin
                    e = quiet(4'b0001); e.rdy = 1'b1; e.drv = 0; expq.push_back(e);
                end
                e = quiet(4'b0001); e.rdy = 1'b1; e.din = 1'b1; e.rin = bit_of(rx); e.drv = 1;
                expq.push_back(e);
                expq.push_back(quiet(4'b1111));
            end
            3'd1: begin
                e = quiet(4'b0010); e.rout = bit_of(ry); e.rin = bit_of(rx); expq.push_back(e);
                expq.push_back(quiet(4'b1111));
            end
            3'd2, 3'd3: begin
                e = quiet(4'b0011); e.rout = bit_of(rx); e.ain = 1'b1; expq.push_back(e);
                e = quiet(4'b0100); e.rout = bit_of(ry); e.gin = 1'b1; e.aop = op[0]; expq.push_back(e);
                e = quiet(4'b0101); e.gout = 1'b1; e.rin = bit_of(rx); expq.push_back(e);
                expq.push_back(quiet(4'b1111));
            end
            3'd4: begin
                for (int i = 0; i < 22; i++) begin
                    e = quiet(4'b0110); e.hlt = 1'b1; e.drv = 3; expq.push_back(e);
                end
            end
            default: expq.push_back(quiet(4'b1111));
        endcase
    endtask

    task automatic check_cyc(input string tag, input exp_t e);
        chk({tag, "/state"}, 32'(state), 32'(e.st));
        chk({tag, "/rin"}, 32'(rin), 32'(e.rin));
        chk({tag, "/rout"}, 32'(rout), 32'(e.rout));
        chk({tag, "/din_out"}, 32'(din_out), 32'(e.din));
        chk({tag, "/a_in"}, 32'(a_in), 32'(e.ain));
        chk({tag, "/g_in"}, 32'(g_in), 32'(e.gin));
        chk({tag, "/g_out"}, 32'(g_out), 32'(e.gout));
        chk({tag, "/alu_op"}, 32'(alu_op), 32'(e.aop));
        chk({tag, "/ready"}, 32'(cu_bus.instr_ready), 32'(e.rdy));
        chk({tag, "/halted"}, 32'(halted), 32'(e.hlt));
        chk({tag, "/retired"}, 32'(retired), ret_model % (1 << CW));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction from START and check every cycle until it completes.
    task automatic run_instr(input string tag, input logic [8:0] w, input int delay, input logic [8:0] imm);
        exp_t e;
        build(w, delay);
        cu_bus.instr       = w;
        cu_bus.instr_valid = 1'b1;
        #2;
        e = quiet(4'b0000); e.rdy = 1'b1;
        check_cyc({tag, "/start"}, e);
        next_cycle();
        foreach (expq[k]) begin
            e = expq[k];
            case (e.drv)
                0: begin cu_bus.instr_valid = 1'b0; cu_bus.instr = 9'($urandom); end
                1: begin cu_bus.instr_valid = 1'b1; cu_bus.instr = imm; end
                3: begin cu_bus.instr_valid = 1'b1; cu_bus.instr = 9'($urandom); end
                default: begin cu_bus.instr_valid = 1'($urandom); cu_bus.instr = 9'($urandom); end
            endcase
            #2;
            check_cyc(tag, e);
            next_cycle();
        end
        cu_bus.instr_valid = 1'b0;
        if (w[8:6] != OP_TERM) ret_model = ret_model + 1;
    endtask

    initial begin
        logic [2:0] rop;
        exp_t       e;

        cu_bus.instr       = '0;
        cu_bus.instr_valid = 1'b0;
        reset              = 1'b1;
        #2;
        check_cyc("reset", quiet(4'b0000));
        next_cycle();
        next_cycle();
        reset = 1'b0;
        #2;
        e = quiet(4'b0000); e.rdy = 1'b1;
        check_cyc("post_reset", e);
        next_cycle();

        run_instr("move", 9'b001_010_011, 0, '0);
        run_instr("add", 9'b010_001_010, 0, '0);
        run_instr("xor", 9'b011_001_010, 0, '0);
        run_instr("load_r5", 9'b000_101_000, 4, 9'h1A5);
        run_instr("illegal", 9'b111_011_101, 0, '0);

        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 6));
            if (rop >= 3'd4) rop = rop + 3'd1;
            run_instr("rand", {rop, 6'($urandom)}, int'($urandom_range(0, 3)), 9'($urandom));
        end

        // Abort an ADD in ALU2 with an asynchronous reset.
        cu_bus.instr       = 9'b010_110_001;
        cu_bus.instr_valid = 1'b1;
        next_cycle();
        cu_bus.instr_valid = 1'b0;
        next_cycle();
        #2;
        e = quiet(4'b0100); e.rout = bit_of(3'd1); e.gin = 1'b1;
        check_cyc("abort_alu2", e);
        reset = 1'b1;
        #1;
        ret_model = 0;
        check_cyc("abort_reset", quiet(4'b0000));
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            e = quiet(4'b0000); e.rdy = 1'b1;
            check_cyc("abort_idle", e);
            next_cycle();
        end

        for (int n = 0; n < (1 << CW) + 1; n++) begin
            run_instr("wrap_nop", {3'($urandom_range(5, 7)), 6'($urandom)}, 0, '0);
        end
        #2;
        chk("wrap_retired", 32'(retired), 32'd1);
        next_cycle();

        run_instr("term", 9'b100_000_000, 0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction-issue and control-strobe generator for the basic CPU. It accepts 9-bit instruction words from the instruction source over a valid/ready handshake and holds them in an instruction register. It sequences the shared START/LOAD/MOVE/ALU/ALU2/ALU3/TERM/DONE state register and drives the one-hot register-file, bus and ALU strobes that execute each instruction on the datapath.

## Interface
- `NREG`, default 8: number of general registers; width of the one-hot `rin`/`rout` strobes.
- `CNT_W`, default 16: width of the retired-instruction counter.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `instr`  in  9: instruction word `{op[8:6], rx[5:3], ry[2:0]}`, or the immediate word during LOAD.
- `instr_valid`  in  1: `instr` is valid this cycle.
- `instr_ready`  out  1: block accepts `instr` this cycle.
- `state`  out  4: current state encoding.
- `rin`  out  NREG: one-hot register write enable.
- `rout`  out  NREG: one-hot register bus-drive select.
- `din_out`  out  1: drive `instr` (the immediate) onto the datapath bus.
- `a_in`  out  1: latch the bus into ALU operand A.
- `g_in`  out  1: latch the ALU result into G.
- `g_out`  out  1: drive G onto the bus.
- `alu_op`  out  1: 0 = add, 1 = xor.
- `halted`  out  1: TERM reached; remains set until reset.
- `retired`  out  CNT_W: count of completed instructions.

## Operation
- Opcodes: LOAD 000, MOVE 001, ADD 010, XOR 011, TERM 100. Opcodes 101–111 are illegal and execute as NOP.
- State encodings: START 0000, LOAD 0001, MOVE 0010, ALU 0011, ALU2 0100, ALU3 0101, TERM 0110, DONE 1111.
- A handshake occurs when `instr_valid & instr_ready`. `instr` is sampled only on a handshake.
- START:
  - `instr_ready=1`.
  - On a handshake, latch IR and branch on the opcode: 000 to LOAD, 001 to MOVE, 010/011 to ALU, 100 to TERM, illegal to DONE.
  - Without a handshake, stay in START.
- LOAD:
  - `instr_ready=1`.
  - In the handshake cycle, `din_out=1` and `rin[rx]=1`, then go to DONE.
  - Without a handshake, stay in LOAD with all strobes 0.
- MOVE: `rout[ry]=1`, `rin[rx]=1`, then go to DONE.
- ALU: `rout[rx]=1`, `a_in=1`, then go to ALU2.
- ALU2: `rout[ry]=1`, `g_in=1`, `alu_op=IR[6]`, then go to ALU3.
- ALU3: `g_out=1`, `rin[rx]=1`, then go to DONE.
- DONE: all strobes 0; `retired` increments by 1 (wraps at 2^CNT_W); then go to START.
- TERM:
  - `halted=1`, `instr_ready=0`, all strobes 0.
  - TERM is absorbing; only reset leaves it.
  - TERM does not increment `retired`.
- Unused encodings in the state register recover to START on the next edge with all strobes 0.
- Strobe outputs are decoded combinationally from the state register, IR and `instr_valid`. They are never registered a second time.
- At most one of `rout`, `g_out` and `din_out` is active in any cycle (single bus driver).

## Timing
- Reset values: `state`=START, IR=0, `retired`=0, `halted`=0, all strobes 0. `instr_ready`=1 once reset deasserts.
- Reset asserted mid-instruction aborts it; no further strobes are issued and `retired` is not incremented.
- Cycle counts, with the instruction word valid on arrival at START:
  - MOVE: 3 cycles (START, MOVE, DONE).
  - ADD/XOR: 5 cycles.
  - LOAD: 3 cycles plus any wait for the immediate.
  - NOP: 2 cycles.
- Back-to-back issue: the next handshake is earliest 1 cycle after DONE, i.e. in START.
- `instr_valid` held high in DONE, ALU*, MOVE or TERM is ignored (`instr_ready=0`).

## Structure
- Shared package `cpu_pkg` holds:
  - state encoding constants;
  - opcode constants;
  - the instruction field positions (op/rx/ry).
- The datapath and test bench import the same package.
- One sub-module: `dec3to8`, a 3-bit to one-hot NREG decoder with enable. It is instantiated twice, once for `rin` and once for `rout`.
- The state register, IR and `retired` counter live in `control_unit`.

## Test plan
- Reset then MOVE: `instr`=001_010_011 valid → `rout`=0000_1000 and `rin`=0000_0100 in the MOVE cycle; `retired`=1 after DONE; 3 cycles total.
- ADD R1,R2: 010_001_010 → ALU: `rout[1]`, `a_in`; ALU2: `rout[2]`, `g_in`, `alu_op`=0; ALU3: `g_out`, `rin[1]`. XOR 011_001_010 gives `alu_op`=1 in ALU2.
- LOAD R5 with the immediate delayed 4 cycles: `state` holds at 0001 with strobes 0; in the handshake cycle `din_out`=1 and `rin`=0010_0000; then DONE.
- TERM (100_000_000): `halted`=1, `instr_ready`=0 and `state`=0110 for 20+ cycles with `instr_valid` high; `retired` unchanged.
- Illegal opcode 111_xxx_xxx → START→DONE→START with no strobes; `retired` increments.
- Reset asserted in ALU2 → outputs clear immediately, `state`=0000; `retired` is unaffected by the aborted instruction. Run 2^CNT_W+1 NOPs with CNT_W=4 → `retired` wraps to 1.
